weight_fetch_seq: RTL and testbench
===================================

// Module: weight_fetch_seq
// PURPOSE
//   Read-side sequencer for the weight ROMs (combinational lookup: data valid in the same cycle as address).
//   Drives the ROM address port and walks a run of COUNT words starting at BASE.
//   Registers each word into a one-entry valid/ready output stage that feeds the MAC datapath.
//   One fetch per cycle while the consumer accepts; stalls cleanly on backpressure.
// PARAMETERS
//   ADDR_W  16     width of ROM address, base_addr, count
//   DATA_W  32     width of signed ROM word / out_data
//   DEPTH   50176  number of ROM words (784x64 layer-1 matrix); addresses wrap modulo DEPTH
// PORTS
//   clk        in   1       rising-edge clock
//   resetn     in   1       asynchronous, active-low reset
//   start      in   1       pulse: begin a run; sampled only in IDLE
//   abort      in   1       synchronous cancel of the active run
//   base_addr  in   ADDR_W  first word address (must be < DEPTH), captured on start
//   count      in   ADDR_W  number of words in the run, captured on start; 0 = empty run
//   mem_addr   out  ADDR_W  address to weight ROM (registered)
//   mem_data   in   DATA_W  signed ROM word for mem_addr, same cycle
//   out_data   out  DATA_W  signed weight word to consumer
//   out_valid  out  1       out_data holds a word
//   out_ready  in   1       consumer accepts when out_valid && out_ready
//   out_last   out  1       qualifies the final word of the run
//   busy       out  1       high in any state other than IDLE
//   done       out  1       one-cycle pulse when run completes (not on abort)
// BEHAVIOUR
//   Reset: state IDLE; mem_addr=0, out_data=0, out_valid=0, out_last=0, busy=0, done=0, remaining=0.
//   States: IDLE, FETCH, DRAIN.
//   IDLE: start=1 -> mem_addr<=base_addr, remaining<=count; count!=0 -> FETCH; count==0 -> done=1 next cycle, stay IDLE.
//   load = FETCH && (!out_valid || out_ready). Output stage is a 1-deep register; no skid buffer.
//   On load: out_data<=mem_data, out_valid<=1, out_last<=(remaining==1), remaining<=remaining-1,
//     mem_addr<=(mem_addr==DEPTH-1) ? 0 : mem_addr+1.
//   FETCH with remaining==1 and load -> DRAIN.
//   FETCH, no load, and out_valid && out_ready -> out_valid<=0.
//   DRAIN: hold out_data/out_last until accepted. On accept -> out_valid<=0, out_last<=0, done<=1 for one cycle, IDLE.
//   Stall: while out_valid && !out_ready, out_data, out_last, and mem_addr are stable.
//   Latency: start captured at edge E0; first out_valid high after E1. Throughput is 1 word/clk when out_ready is held high.
//   Run length: exactly count words leave the block; out_last is asserted on the final word only.
//   Wrap: base_addr+count > DEPTH continues from address 0 (e.g. DEPTH-1, 0, 1, ...).
//   start while busy: ignored; no parameter recapture.
//   abort (any state, priority over start/load): next edge -> IDLE, out_valid=0, out_last=0, remaining=0, no done.
//   mem_addr keeps its last value after a run or abort. done and start are never high in the same accepted cycle.
//   Async reset mid-run: all outputs return to reset values immediately; the next run needs a new start.
//   Width: remaining is ADDR_W bits unsigned. The max count (2^ADDR_W-1) runs without overflow.
// TESTING
//   1. ROM[i]=i, base=0, count=4, out_ready=1 -> out_data 0,1,2,3 on 4 consecutive cycles; last on 3; done 1 cycle later.
//   2. base=10, count=3, out_ready toggling 1,0,0,1,... -> words 10,11,12 each held while stalled; no duplicates or drops.
//   3. base=DEPTH-2, count=4 -> mem_addr sequence 50174,50175,0,1; out_last on the word from addr 1.
//   4. count=0, start -> no out_valid; done pulses exactly once; busy stays 0.
//   5. count=8, abort after 3 accepted words -> out_valid=0 next cycle, IDLE, no done; new start base=0 count=2 -> 0,1.
//   6. resetn low mid-run (count=8), then released -> all outputs 0; start while busy is ignored (recapture check).

Source files
------------

// File: rtl/weight_fetch_seq.sv
// ---------------------------------------------------------------------------
// weight_fetch_seq
//   Read-side sequencer for a combinational weight ROM. A run of `count`
//   words starting at `base_addr` is streamed through a one-entry valid/ready
//   output register into the MAC datapath. The sequencer fetches one word per
//   cycle while the consumer keeps accepting, and holds everything steady when
//   the consumer applies backpressure. ROM addresses wrap modulo DEPTH.
//
// Ports
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset
//   start      begin a run (only looked at while idle)
//   abort      synchronous cancel of the active run, no done pulse
//   base_addr  first ROM address of the run, captured on start
//   count      number of words in the run, captured on start (0 = empty run)
//   mem_addr   registered ROM address
//   mem_data   ROM word for mem_addr, valid in the same cycle
//   out_data   weight word to the consumer
//   out_valid  out_data holds a word
//   out_ready  consumer accepts when out_valid && out_ready
//   out_last   marks the final word of the run
//   busy       high whenever not idle
//   done       one-cycle pulse when a run completes normally
// ---------------------------------------------------------------------------
module weight_fetch_seq #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 50176
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] count,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] remaining;
    logic              load;
    logic              accept;
    logic              start_ok;
    logic [ADDR_W-1:0] next_addr;

    // The output register can take a new word when it is empty or when its
    // current word is leaving in this same cycle.
    assign load   = (state == FETCH) && (!out_valid || out_ready);
    assign accept = out_valid && out_ready;

    // A start arriving in the cycle that done is shown is not taken, so done
    // and an accepted start never coincide.
    assign start_ok = start && !done;

    assign next_addr = (mem_addr == LAST_ADDR) ? '0 : mem_addr + ONE;

    assign busy = (state != IDLE);

    // NOTE: every register in this block is assigned with <= so all of them
    // update together on the edge; blocking = here would let later lines see
    // half-updated state and create simulation/synthesis mismatches.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            mem_addr  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            remaining <= '0;
            done      <= 1'b0;
        end else begin
            // NOTE: done defaults low each cycle so it can only ever be a
            // single-cycle pulse; the branches below only ever raise it.
            done <= 1'b0;

            if (abort) begin
                // mem_addr and out_data deliberately keep their last values.
                state     <= IDLE;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                remaining <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_ok) begin
                            mem_addr  <= base_addr;
                            remaining <= count;
                            if (count != '0) begin
                                state <= FETCH;
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end

                    FETCH: begin
                        if (load) begin
                            out_data  <= mem_data;
                            out_valid <= 1'b1;
                            out_last  <= (remaining == ONE);
                            remaining <= remaining - ONE;
                            mem_addr  <= next_addr;
                            if (remaining == ONE) begin
                                state <= DRAIN;
                            end
                        end else if (accept) begin
                            out_valid <= 1'b0;
                        end
                    end

                    DRAIN: begin
                        // Final word is held until the consumer takes it.
                        if (accept) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                            state     <= IDLE;
                        end
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_weight_fetch_seq.sv
// ---------------------------------------------------------------------------
// tb_weight_fetch_seq
//   Directed self-checking bench for weight_fetch_seq. The ROM is modelled as
//   ROM[i] = i, so every output word also identifies the address it came from.
//   Outputs are sampled and inputs driven on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_weight_fetch_seq;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 50176;

    logic              clk;
    logic              resetn;
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] count;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;
    logic              done;

    int n_checks = 0;
    int n_fails  = 0;

    weight_fetch_seq #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .abort    (abort),
        .base_addr(base_addr),
        .count    (count),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last),
        .busy     (busy),
        .done     (done)
    );

    // Combinational ROM: ROM[i] = i.
    assign mem_data = {{(DATA_W-ADDR_W){1'b0}}, mem_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     tag, got, got, exp, exp, $time);
        end
    endtask

    // Starts a run and consumes it. mode 0: out_ready held high;
    // mode 1: out_ready pattern 1,0,0,1,0,0,... . With poke set, a second
    // start carrying different parameters is pulsed while the run is busy and
    // must be ignored.
    task automatic run_words(input logic [15:0] base, input logic [15:0] cnt,
                             input int mode, input bit poke);
        int k = 0;
        int c = 0;
        int a;
        logic rdy;
        @(negedge clk);
        start     = 1'b1;
        base_addr = base;
        count     = cnt;
        out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("run_lat_valid", {31'b0, out_valid}, 32'd0);
        check("run_busy", {31'b0, busy}, 32'd1);
        check("run_base_addr", {16'b0, mem_addr}, {16'b0, base});
        while (k < int'(cnt) && c < 400) begin
            rdy = (mode == 0) ? 1'b1 : ((c % 3) == 0);
            if (out_valid) begin
                a = (int'(base) + k) % DEPTH;
                check("run_data", out_data, 32'(a));
                check("run_last", {31'b0, out_last}, {31'b0, (k == int'(cnt) - 1)});
                check("run_addr", {16'b0, mem_addr}, 32'((a + 1) % DEPTH));
                if (rdy) k++;
            end
            out_ready = rdy;
            start     = poke && (c == 1);
            if (start) begin
                base_addr = 16'd500;
                count     = 16'd9;
            end
            c++;
            @(negedge clk);
        end
        start = 1'b0;
        check("run_words_seen", 32'(k), 32'(cnt));
        check("run_done", {31'b0, done}, 32'd1);
        check("run_end_valid", {31'b0, out_valid}, 32'd0);
        check("run_end_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        check("run_done_pulse", {31'b0, done}, 32'd0);
    endtask

    initial begin
        resetn    = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        base_addr = '0;
        count     = '0;
        out_ready = 1'b0;

        // Reset values
        #1;
        check("rst_mem_addr", {16'b0, mem_addr}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_last", {31'b0, out_last}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // 1. base 0, count 4, ready high: latency and one word per clock
        start = 1'b1; base_addr = 16'd0; count = 16'd4; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t1_lat_valid", {31'b0, out_valid}, 32'd0);
        check("t1_busy", {31'b0, busy}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t1_valid", {31'b0, out_valid}, 32'd1);
            check("t1_data", out_data, 32'(i));
            check("t1_last", {31'b0, out_last}, {31'b0, (i == 3)});
        end
        @(negedge clk);
        check("t1_done", {31'b0, done}, 32'd1);
        check("t1_valid_off", {31'b0, out_valid}, 32'd0);
        check("t1_busy_off", {31'b0, busy}, 32'd0);
        @(negedge clk);
        check("t1_done_pulse", {31'b0, done}, 32'd0);

        // 2. base 10, count 3, backpressure pattern
        run_words(16'd10, 16'd3, 1, 1'b0);

        // 3. address wrap at the top of the ROM
        run_words(16'(DEPTH - 2), 16'd4, 0, 1'b0);

        // 4. empty run
        @(negedge clk);
        start = 1'b1; base_addr = 16'd7; count = 16'd0; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t4_done", {31'b0, done}, 32'd1);
        check("t4_busy", {31'b0, busy}, 32'd0);
        check("t4_valid", {31'b0, out_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_done_once", {31'b0, done}, 32'd0);
            check("t4_valid_idle", {31'b0, out_valid}, 32'd0);
        end

        // 5. abort after three accepted words, then a fresh run
        start = 1'b1; base_addr = 16'd100; count = 16'd8; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_data", out_data, 32'(100 + i));
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t5_abort_valid", {31'b0, out_valid}, 32'd0);
        check("t5_abort_busy", {31'b0, busy}, 32'd0);
        check("t5_abort_done", {31'b0, done}, 32'd0);
        check("t5_abort_last", {31'b0, out_last}, 32'd0);
        @(negedge clk);
        check("t5_no_done", {31'b0, done}, 32'd0);
        check("t5_idle_valid", {31'b0, out_valid}, 32'd0);
        run_words(16'd0, 16'd2, 0, 1'b0);

        // 6. asynchronous reset mid-run, then start-while-busy is ignored
        @(negedge clk);
        start = 1'b1; base_addr = 16'd0; count = 16'd8; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_pre_valid", {31'b0, out_valid}, 32'd1);
        #2 resetn = 1'b0;
        #1;
        check("t6_rst_mem_addr", {16'b0, mem_addr}, 32'd0);
        check("t6_rst_data", out_data, 32'd0);
        check("t6_rst_valid", {31'b0, out_valid}, 32'd0);
        check("t6_rst_last", {31'b0, out_last}, 32'd0);
        check("t6_rst_busy", {31'b0, busy}, 32'd0);
        check("t6_rst_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_stay_idle", {31'b0, busy}, 32'd0);
            check("t6_stay_invalid", {31'b0, out_valid}, 32'd0);
        end
        run_words(16'd200, 16'd3, 1, 1'b1);
        repeat (3) @(negedge clk);
        check("t6_no_recapture", {31'b0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
